// File: rtl/grid_audio_feeder.sv
// grid_audio_feeder: requests updates from the node grid, captures the centre-node amplitude
// into a small first-word-fall-through FIFO, and presents left-aligned samples to an audio sink.
// A watchdog aborts requests that the grid never answers.

module grid_audio_feeder #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned AMP_W      = 18,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  start_update,
    input  logic                  done_update_to_fifo,
    input  logic [AMP_W-1:0]      center_node_amp,
    output logic [31:0]           audio_data,
    output logic                  audio_valid,
    input  logic                  audio_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PAD_W = 32 - AMP_W;
    localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [WD_W-1:0]     WdLast    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRequest, StWaitDone} state_e;

    state_e                state_q, state_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [AMP_W-1:0]      mem_q [DEPTH];
    logic                  overflow_q, timeout_q;
    logic                  timeout_set;
    logic                  full, push, pop, drop;

    // FIFO handshake: a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        full    = (count_q == FullCount);
        pop     = (count_q != '0) && audio_ready;
        push    = done_update_to_fifo && (!full || pop);
        drop    = done_update_to_fifo && full && !pop;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Request FSM next state; the watchdog counts cycles spent in WAIT_DONE.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        timeout_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run && !full) begin
                    state_d = StRequest;
                end
            end
            StRequest: begin
                state_d = StWaitDone;
                wd_d    = '0;
            end
            StWaitDone: begin
                if (done_update_to_fifo) begin
                    state_d = StIdle;
                end else if (wd_q == WdLast) begin
                    state_d     = StIdle;
                    timeout_set = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointers, occupancy and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wd_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Sample storage; contents are masked by occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= center_node_amp;
        end
    end

    // Outputs; audio_data is forced to zero whenever the FIFO is empty (including reset).
    always_comb begin
        start_update = (state_q == StRequest);
        audio_valid  = (count_q != '0);
        audio_data   = audio_valid ? {mem_q[rd_ptr_q], {PAD_W{1'b0}}} : 32'd0;
        fill_level   = count_q;
        overflow     = overflow_q;
        timeout      = timeout_q;
    end

endmodule

// File: tb/tb_grid_audio_feeder.sv
// Directed bench for grid_audio_feeder: basic cadence, fill/backpressure, overflow,
// watchdog timeout, asynchronous reset, and a wrap test with simultaneous push/pop.

module tb_grid_audio_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        start_update;
    logic        done_update_to_fifo;
    logic [17:0] center_node_amp;
    logic [31:0] audio_data;
    logic        audio_valid;
    logic        audio_ready = 1'b0;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        timeout;

    // Grid model and direct injection share the done/amp inputs.
    logic        done_g = 1'b0, done_inj = 1'b0;
    logic [17:0] g_amp = '0, inj_amp = '0;
    logic [17:0] next_amp = '0;
    bit          grid_on = 1'b0, grid_fixed = 1'b0;
    int          g_cnt = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          n_checks = 0, n_errors = 0;
    int          fill_target = 0;

    assign done_update_to_fifo = done_g | done_inj;
    assign center_node_amp     = done_inj ? inj_amp : g_amp;

    grid_audio_feeder #(
        .DEPTH_LOG2 (3),
        .AMP_W      (18),
        .TIMEOUT    (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .start_update        (start_update),
        .done_update_to_fifo (done_update_to_fifo),
        .center_node_amp     (center_node_amp),
        .audio_data          (audio_data),
        .audio_valid         (audio_valid),
        .audio_ready         (audio_ready),
        .fill_level          (fill_level),
        .overflow            (overflow),
        .timeout             (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count start pulses and arm the grid: done is high 5 cycles after the edge that sees start.
    always @(negedge clk) begin
        if (start_update) begin
            start_cnt = start_cnt + 1;
            if (grid_on) g_cnt = 6;
        end
    end

    always @(posedge clk) begin
        #1;
        done_g = 1'b0;
        if (g_cnt != 0) begin
            g_cnt = g_cnt - 1;
            if (g_cnt == 0 && grid_on) begin
                done_g = 1'b1;
                if (grid_fixed) begin
                    g_amp = 18'd17;
                end else begin
                    g_amp    = next_amp;
                    next_amp = next_amp + 18'd1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [17:0] a);
        return {a, 14'b0};
    endfunction

    function automatic logic probe(input int sel);
        case (sel)
            0:       return start_update;
            1:       return done_update_to_fifo;
            2:       return audio_valid;
            default: return (32'(fill_level) == 32'(fill_target));
        endcase
    endfunction

    // Advance negedge by negedge until the probed condition holds or the budget runs out.
    task automatic wait_for(input string tag, input int sel, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(sel) && n < limit);
        check_eq(tag, 32'(probe(sel)), 32'd1);
    endtask

    logic [17:0] amps [20];
    logic [17:0] q [$];

    initial begin
        int c [3];
        int saved;
        int k;
        int sent;
        bit pop, push;

        // Reset state
        #3 reset = 1'b0;
        #1;
        check_eq("rst_fill", 32'(fill_level), 32'd0);
        check_eq("rst_valid", 32'(audio_valid), 32'd0);
        check_eq("rst_start", 32'(start_update), 32'd0);
        check_eq("rst_data", audio_data, 32'd0);
        check_eq("rst_flags", {30'd0, overflow, timeout}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Basic cadence: amp 17 -> 0x00044000, starts 8 cycles apart
        grid_on = 1'b1; grid_fixed = 1'b1; audio_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_for($sformatf("basic_start%0d", i), 0, 20);
            c[i] = cyc;
            @(negedge clk);
            check_eq("basic_pulse_width", 32'(start_update), 32'd0);
            wait_for("basic_done", 1, 20);
            @(negedge clk);
            check_eq("basic_valid", 32'(audio_valid), 32'd1);
            check_eq("basic_data", audio_data, 32'h0004_4000);
        end
        check_eq("basic_spacing01", 32'(c[1] - c[0]), 32'd8);
        check_eq("basic_spacing12", 32'(c[2] - c[1]), 32'd8);

        // Fill with backpressure: amps 1..8
        run = 1'b0;
        repeat (20) @(negedge clk);
        grid_fixed = 1'b0; next_amp = 18'd1; audio_ready = 1'b0; run = 1'b1;
        fill_target = 8;
        wait_for("fill_reach8", 3, 150);
        saved = start_cnt;
        repeat (20) @(negedge clk);
        check_eq("fill_no_more_req", 32'(start_cnt), 32'(saved));
        check_eq("fill_level8", 32'(fill_level), 32'd8);
        check_eq("fill_no_overflow", 32'(overflow), 32'd0);
        check_eq("fill_head", audio_data, exp_data(18'd1));

        // Overflow: unsolicited -5 while full and not popping
        done_inj = 1'b1; inj_amp = -18'sd5;
        @(negedge clk);
        done_inj = 1'b0;
        check_eq("ovf_fill", 32'(fill_level), 32'd8);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_head", audio_data, exp_data(18'd1));

        // Drain in order; requests resume and deliver 9, 10
        audio_ready = 1'b1;
        k = 1;
        for (int n = 0; n < 200 && k <= 10; n++) begin
            if (audio_valid && audio_ready) begin
                check_eq($sformatf("drain_%0d", k), audio_data, exp_data(18'(k)));
                k++;
            end
            @(negedge clk);
        end
        check_eq("drain_count", 32'(k), 32'd11);
        check_eq("req_resumed", 32'(start_cnt > saved), 32'd1);

        // Watchdog: grid silent; WAIT_DONE lasts 16 cycles, then flag and re-request
        run = 1'b0;
        repeat (20) @(negedge clk);
        grid_on = 1'b0; run = 1'b1;
        wait_for("to_start", 0, 20);
        repeat (16) @(negedge clk);
        check_eq("to_not_yet", 32'(timeout), 32'd0);
        @(negedge clk);
        check_eq("to_flag", 32'(timeout), 32'd1);
        check_eq("to_idle_no_start", 32'(start_update), 32'd0);
        @(negedge clk);
        check_eq("to_next_start", 32'(start_update), 32'd1);
        run = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-WAIT_DONE with three samples held
        grid_on = 1'b1; grid_fixed = 1'b0; next_amp = 18'd1; audio_ready = 1'b0; run = 1'b1;
        fill_target = 3;
        wait_for("pre_rst_fill3", 3, 100);
        wait_for("pre_rst_start", 0, 20);
        @(posedge clk);
        #2;
        check_eq("pre_rst_flags", {30'd0, overflow, timeout}, 32'd3);
        reset = 1'b0; grid_on = 1'b0; g_cnt = 0;
        #1;
        check_eq("arst_fill", 32'(fill_level), 32'd0);
        check_eq("arst_valid", 32'(audio_valid), 32'd0);
        check_eq("arst_data", audio_data, 32'd0);
        check_eq("arst_start", 32'(start_update), 32'd0);
        check_eq("arst_flags", {30'd0, overflow, timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_eq("rel_fill", 32'(fill_level), 32'd0);
        next_amp = 18'd50; audio_ready = 1'b1; grid_on = 1'b1; run = 1'b1;
        wait_for("rel_valid", 2, 40);
        check_eq("rel_first_data", audio_data, exp_data(18'd50));
        run = 1'b0;
        repeat (20) @(negedge clk);
        grid_on = 1'b0;
        check_eq("wrap_pre_empty", 32'(fill_level), 32'd0);

        // Wrap: 20 injected samples, ready toggling, push+pop while full
        for (int i = 0; i < 20; i++) amps[i] = 18'(i * 7000 - 60000);
        sent = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("wrap_fill", 32'(fill_level), 32'(q.size()));
            check_eq("wrap_valid", 32'(audio_valid), 32'(q.size() != 0));
            if (q.size() != 0) check_eq($sformatf("wrap_data_c%0d", i), audio_data, exp_data(q[0]));
            audio_ready = i[0];
            pop  = audio_ready && (q.size() != 0);
            push = (sent < 20) && ((q.size() < 8) || pop);
            done_inj = push;
            inj_amp  = amps[sent % 20];
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(amps[sent]);
                sent++;
            end
        end
        done_inj = 1'b0;
        check_eq("wrap_all_sent", 32'(sent), 32'd20);
        check_eq("wrap_drained", 32'(fill_level), 32'd0);
        check_eq("wrap_no_overflow", 32'(overflow), 32'd0);
        check_eq("wrap_no_timeout", 32'(timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

endmodule
